mux_2_3_inputs: RTL and testbench
=================================

// Module: mux_2_3_inputs
// PURPOSE
//  Operand/address selection block for the decode stage: one 2:1 mux (next-PC
//  select: branch vs jump/jr target) and two independent 3:1 forwarding muxes
//  (branch-comparator operands: regfile / EX-MEM ALU result / MEM-WB data).
//  Combinational by default; an optional output register stage is provided.
//  Sits between the register file, forwarding unit and fetch-stage PC logic.
// PARAMETERS
//  WIDTH    32  data width of every data input and output
//  OUT_REG  0   0 = purely combinational outputs; 1 = outputs registered on Clk
// PORTS
//  Clk        in   1      clock (used only when OUT_REG=1)
//  Rst_n      in   1      asynchronous active-low reset
//  m2_in0     in   WIDTH  2:1 input 0 (branch address)
//  m2_in1     in   WIDTH  2:1 input 1 (jump / jr address)
//  m2_sel     in   1      2:1 select (jump control line)
//  m2_out     out  WIDTH  2:1 result (next address to fetch)
//  ma_in0     in   WIDTH  3:1 mux A input 0 (regfile ReadData1)
//  ma_in1     in   WIDTH  3:1 mux A input 1 (EX/MEM ALU result)
//  ma_in2     in   WIDTH  3:1 mux A input 2 (MEM/WB data)
//  ma_sel     in   2      3:1 mux A select (ForwardD)
//  ma_out     out  WIDTH  3:1 mux A result
//  mb_in0     in   WIDTH  3:1 mux B input 0 (regfile ReadData2)
//  mb_in1     in   WIDTH  3:1 mux B input 1 (EX/MEM ALU result)
//  mb_in2     in   WIDTH  3:1 mux B input 2 (MEM/WB data)
//  mb_sel     in   2      3:1 mux B select (ForwardE)
//  mb_out     out  WIDTH  3:1 mux B result
//  sel_err    out  2      {B,A} flag: select value 2'b11 presented this cycle
// BEHAVIOUR
//  - 2:1: m2_sel=0 -> m2_in0; m2_sel=1 -> m2_in1. X/Z on sel -> output in0.
//  - 3:1 (A and B identical, fully independent):
//    sel=2'b00 -> in0; 2'b01 -> in1; 2'b10 -> in2;
//    sel=2'b11 (illegal) -> in0 (safe default = no forwarding), sel_err bit=1.
//  - sel_err[0] tracks ma_sel==3, sel_err[1] tracks mb_sel==3; else 0.
//  - Pure bit-for-bit pass-through; no arithmetic, no width change.
//  - OUT_REG=0: zero latency; outputs follow inputs combinationally; Clk and
//    Rst_n have no effect on data (Rst_n does NOT force outputs low).
//  - OUT_REG=1: all outputs (incl. sel_err) captured on posedge Clk, latency
//    exactly 1 cycle; Rst_n=0 asynchronously clears all outputs to 0 and holds
//    them at 0 while low; first capture is the first posedge after Rst_n rises.
//  - Reset asserted mid-operation (OUT_REG=1): outputs drop to 0 immediately,
//    independent of Clk; no pending value survives.
//  - Simultaneous select changes on all three muxes are resolved independently
//    in the same cycle; no priority between muxes.
//  - No internal state other than the optional output registers.
// TESTING
//  - 2:1: in0=32'h0000_1000, in1=32'h0040_0020; sel 0 -> 32'h0000_1000,
//    sel 1 -> 32'h0040_0020, sel X -> 32'h0000_1000.
//  - 3:1 A sweep: in0=12, in1=30, in2=70; sel 0/1/2/3 -> 12/30/70/12,
//    sel_err[0]=0/0/0/1; mux B held at sel 0 stays = mb_in0, sel_err[1]=0.
//  - Independence: ma_sel=1, mb_sel=2, in1=32'hDEAD_BEEF, in2=32'h0000_0005
//    -> ma_out=32'hDEAD_BEEF, mb_out=32'h0000_0005 same cycle.
//  - Width edge: in1=32'hFFFF_FFFF, in0=0, sel=1 -> all 32 bits = 1; sel=0 -> 0.
//  - OUT_REG=1 latency: change ma_sel 0->2 before edge N -> ma_out updates
//    at edge N, not before; m2_out likewise one cycle after m2_sel toggle.
//  - OUT_REG=1 reset: drive Rst_n=0 between edges with nonzero outputs -> all
//    outputs 0 immediately; release -> valid data after next posedge Clk.

Source files
------------

// File: rtl/mux_2_3_inputs.sv
// mux_2_3_inputs: decode-stage next-PC 2:1 mux plus two 3:1 forwarding muxes, optional output register
module mux_2_3_inputs #(
  parameter int WIDTH   = 32,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] m2_in0,
  input  logic [WIDTH-1:0] m2_in1,
  input  logic             m2_sel,
  output logic [WIDTH-1:0] m2_out,
  input  logic [WIDTH-1:0] ma_in0,
  input  logic [WIDTH-1:0] ma_in1,
  input  logic [WIDTH-1:0] ma_in2,
  input  logic [1:0]       ma_sel,
  output logic [WIDTH-1:0] ma_out,
  input  logic [WIDTH-1:0] mb_in0,
  input  logic [WIDTH-1:0] mb_in1,
  input  logic [WIDTH-1:0] mb_in2,
  input  logic [1:0]       mb_sel,
  output logic [WIDTH-1:0] mb_out,
  output logic [1:0]       sel_err
);
  logic [WIDTH-1:0] m2_d, ma_d, mb_d;
  logic [1:0]       err_d;
  // unknown or illegal selects fall back to input 0, i.e. no redirect / no forwarding
  always_comb begin
    m2_d  = (m2_sel === 1'b1) ? m2_in1 : m2_in0;
    ma_d  = (ma_sel == 2'b01) ? ma_in1 : (ma_sel == 2'b10) ? ma_in2 : ma_in0;
    mb_d  = (mb_sel == 2'b01) ? mb_in1 : (mb_sel == 2'b10) ? mb_in2 : mb_in0;
    err_d = {mb_sel == 2'b11, ma_sel == 2'b11};
  end
  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] m2_q, ma_q, mb_q;
    logic [1:0]       err_q;
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        m2_q  <= '0;
        ma_q  <= '0;
        mb_q  <= '0;
        err_q <= '0;
      end else begin
        m2_q  <= m2_d;
        ma_q  <= ma_d;
        mb_q  <= mb_d;
        err_q <= err_d;
      end
    end
    assign m2_out  = m2_q;
    assign ma_out  = ma_q;
    assign mb_out  = mb_q;
    assign sel_err = err_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = Clk ^ Rst_n;
    assign m2_out  = m2_d;
    assign ma_out  = ma_d;
    assign mb_out  = mb_d;
    assign sel_err = err_d;
  end
endmodule

// File: tb/tb_mux_2_3_inputs.sv
// tb_mux_2_3_inputs: scoreboard bench driving a combinational and a registered instance in parallel
module tb_mux_2_3_inputs;
  typedef struct packed {
    logic [31:0] m2;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [1:0]  err;
  } res_t;

  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic [31:0] m2_in0, m2_in1, ma_in0, ma_in1, ma_in2, mb_in0, mb_in1, mb_in2;
  logic        m2_sel;
  logic [1:0]  ma_sel, mb_sel;
  logic [31:0] c_m2, c_ma, c_mb, r_m2, r_ma, r_mb;
  logic [1:0]  c_err, r_err;
  res_t        q_comb[$], q_reg[$];
  res_t        prev_reg, e;
  int          n_chk = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  mux_2_3_inputs #(.WIDTH(32), .OUT_REG(1'b0)) u_comb (
    .Clk(Clk), .Rst_n(Rst_n),
    .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel), .m2_out(c_m2),
    .ma_in0(ma_in0), .ma_in1(ma_in1), .ma_in2(ma_in2), .ma_sel(ma_sel), .ma_out(c_ma),
    .mb_in0(mb_in0), .mb_in1(mb_in1), .mb_in2(mb_in2), .mb_sel(mb_sel), .mb_out(c_mb),
    .sel_err(c_err)
  );

  mux_2_3_inputs #(.WIDTH(32), .OUT_REG(1'b1)) u_reg (
    .Clk(Clk), .Rst_n(Rst_n),
    .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel), .m2_out(r_m2),
    .ma_in0(ma_in0), .ma_in1(ma_in1), .ma_in2(ma_in2), .ma_sel(ma_sel), .ma_out(r_ma),
    .mb_in0(mb_in0), .mb_in1(mb_in1), .mb_in2(mb_in2), .mb_sel(mb_sel), .mb_out(r_mb),
    .sel_err(r_err)
  );

  function automatic res_t model();
    res_t r;
    r.m2 = (m2_sel === 1'b1) ? m2_in1 : m2_in0;
    case (ma_sel)
      2'd1:    r.ma = ma_in1;
      2'd2:    r.ma = ma_in2;
      default: r.ma = ma_in0;
    endcase
    case (mb_sel)
      2'd1:    r.mb = mb_in1;
      2'd2:    r.mb = mb_in2;
      default: r.mb = mb_in0;
    endcase
    r.err = {mb_sel == 2'd3, ma_sel == 2'd3};
    return r;
  endfunction

  task automatic check(input string tag, input logic [97:0] got, input logic [97:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic res_t comb_out();
    return '{c_m2, c_ma, c_mb, c_err};
  endfunction

  function automatic res_t reg_out();
    return '{r_m2, r_ma, r_mb, r_err};
  endfunction

  // Call just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    q_comb.push_back(model());
    q_reg.push_back(model());
    #1;
    check({tag, "_comb"}, comb_out(), q_comb.pop_front());
    check({tag, "_reg_hold"}, reg_out(), prev_reg);
    @(posedge Clk);
    #1;
    prev_reg = q_reg.pop_front();
    check({tag, "_reg"}, reg_out(), prev_reg);
    @(negedge Clk);
  endtask

  task automatic set_all(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    m2_in0 = v0; m2_in1 = v1;
    ma_in0 = v0; ma_in1 = v1; ma_in2 = v2;
    mb_in0 = v0; mb_in1 = v1; mb_in2 = v2;
  endtask

  initial begin
    set_all(32'h0, 32'h0, 32'h0);
    m2_sel = 1'b0; ma_sel = 2'd0; mb_sel = 2'd0;
    prev_reg = '0;
    #2;
    check("reset_reg", reg_out(), '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    m2_in0 = 32'h0000_1000; m2_in1 = 32'h0040_0020;
    mb_in0 = 32'h1111_2222; mb_in1 = 32'h3333_4444; mb_in2 = 32'h5555_6666;
    ma_in0 = 32'd12; ma_in1 = 32'd30; ma_in2 = 32'd70;
    m2_sel = 1'b0; step("m2_sel0");
    check("m2_sel0_const", {66'h0, c_m2}, {66'h0, 32'h0000_1000});
    m2_sel = 1'b1; step("m2_sel1");
    check("m2_sel1_const", {66'h0, c_m2}, {66'h0, 32'h0040_0020});
    m2_sel = 1'bx; step("m2_selx");
    m2_sel = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ma_sel = 2'(s);
      step($sformatf("ma_sweep%0d", s));
      check($sformatf("ma_sweep%0d_const", s), {64'h0, c_ma, c_err},
            {64'h0, (s == 1) ? 32'd30 : (s == 2) ? 32'd70 : 32'd12, 1'b0, s == 3});
    end
    ma_sel = 2'd1; mb_sel = 2'd2;
    ma_in1 = 32'hDEAD_BEEF; mb_in2 = 32'h0000_0005;
    step("indep");
    check("indep_const", {34'h0, c_ma, c_mb}, {34'h0, 32'hDEAD_BEEF, 32'h0000_0005});
    set_all(32'h0, 32'hFFFF_FFFF, 32'h0);
    m2_sel = 1'b1; ma_sel = 2'd1; mb_sel = 2'd1; step("width_ones");
    m2_sel = 1'b0; ma_sel = 2'd0; mb_sel = 2'd0; step("width_zero");
    ma_sel = 2'd3; mb_sel = 2'd3; set_all(32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003);
    step("both_illegal");
    for (int i = 0; i < 24; i++) begin
      set_all($urandom, $urandom, $urandom);
      mb_in0 = $urandom; mb_in1 = $urandom; mb_in2 = $urandom;
      m2_sel = 1'($urandom_range(0, 1));
      ma_sel = 2'($urandom_range(0, 3));
      mb_sel = 2'($urandom_range(0, 3));
      step($sformatf("rnd%0d", i));
    end
    set_all(32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D);
    m2_sel = 1'b1; ma_sel = 2'd2; mb_sel = 2'd3;
    step("pre_rst");
    e = model();
    #2 Rst_n = 1'b0;
    #1;
    check("rst_async", reg_out(), '0);
    check("rst_comb_unaffected", comb_out(), e);
    @(posedge Clk);
    #1;
    check("rst_hold", reg_out(), '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("rst_release", reg_out(), '0);
    @(posedge Clk);
    #1;
    check("rst_first_capture", reg_out(), e);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
